// File: rtl/sprot_checker.sv
// rtl/sprot_checker.sv - receiver/checker for the sprot start/a/b handshake
// Registered completion/error pulses, sticky error code and saturating counters.
module sprot_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             prot_err,
  output logic             xfer_end,
  output logic [1:0]       err_code,
  output logic             err_sticky,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} state_t;

  localparam logic [1:0]       CODE_STRAY = 2'd1;
  localparam logic [1:0]       CODE_BAD_A = 2'd2;
  localparam logic [1:0]       CODE_BAD_B = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t     state, state_nxt;
  logic       ev_err, ev_end;
  logic [1:0] code_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ev_err    = 1'b0;
    ev_end    = 1'b0;
    code_nxt  = 2'd0;
    case (state)
      IDLE: begin
        if (a || b) begin
          ev_err   = 1'b1;
          code_nxt = CODE_STRAY;
        end else if (start) begin
          state_nxt = WAIT_A;
        end
      end
      WAIT_A: begin
        if (a && !b && !start) begin
          state_nxt = WAIT_B;
        end else begin
          ev_err    = 1'b1;
          code_nxt  = CODE_BAD_A;
          state_nxt = IDLE;
        end
      end
      WAIT_B: begin
        // A start coincident with a good b chains straight into the next transfer.
        if (b && !a) begin
          ev_end    = 1'b1;
          state_nxt = start ? WAIT_A : IDLE;
        end else begin
          ev_err    = 1'b1;
          code_nxt  = CODE_BAD_B;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prot_err   <= 1'b0;
      xfer_end   <= 1'b0;
      busy       <= 1'b0;
      err_code   <= 2'd0;
      err_sticky <= 1'b0;
      xfer_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      prot_err <= ev_err;
      xfer_end <= ev_end;
      busy     <= (state_nxt != IDLE);
      // clr overrides status and counters but never suppresses the pulses above.
      if (clr) begin
        err_code   <= 2'd0;
        err_sticky <= 1'b0;
        xfer_cnt   <= '0;
        err_cnt    <= '0;
      end else begin
        if (ev_err) begin
          err_code   <= code_nxt;
          err_sticky <= 1'b1;
          if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
        end
        if (ev_end && xfer_cnt != CNT_MAX) xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/sprot_checker.md
Name: sprot_checker

Overview:
- Receiving end of the sprot start/a/b handshake.
- Samples `start`, `a` and `b` on every rising edge of `clk`.
- Enforces the sequence: `start` in cycle N, then `a` alone in N+1, then `b` alone in N+2.
- Reports completion on `xfer_end` and violations on `prot_err`, with an error code, a sticky flag and saturating transfer/error counters for the testbench and status logic.

Parameters:
- `CNT_W`, default 8: width of `xfer_cnt` and `err_cnt`. Legal range 1..32.

Ports:
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begins a transfer.
- `a` input 1: first data phase strobe.
- `b` input 1: second data phase strobe.
- `clr` input 1: synchronous clear of `err_sticky`, `err_code` and both counters.
- `prot_err` output 1: one-cycle pulse on a protocol violation.
- `xfer_end` output 1: one-cycle pulse on a legal transfer completion.
- `err_code` output 2: code of the last error. 0 none, 1 STRAY, 2 BAD_A, 3 BAD_B.
- `err_sticky` output 1: set by any error, held until `clr` or `rst`.
- `busy` output 1: high while the FSM is in WAIT_A or WAIT_B.
- `xfer_cnt` output `CNT_W`: saturating count of completed transfers.
- `err_cnt` output `CNT_W`: saturating count of errors.

Behaviour:
- Reset: one clock (`clk`); `rst` is asynchronous and active-high.
  - While `rst` is high, every output is 0 and the FSM is in IDLE.
  - Takes effect immediately, including mid-transfer; a partial transfer is discarded and produces no pulse.
- All outputs are registered.
  - A decision made on the sample taken at edge E appears after edge E and holds for one cycle (pulses).
  - Latency: `start` sampled at edge N, `a` at N+1, `b` at N+2 → `xfer_end` high in the cycle after edge N+2.
- FSM states: IDLE, WAIT_A, WAIT_B. `busy` is high when the state is WAIT_A or WAIT_B, and is a registered state decode.
- IDLE:
  - `start`=1, `a`=0, `b`=0 → WAIT_A.
  - `start`=1 with `a` or `b` high → STRAY error; stay in IDLE.
  - `start`=0 with `a` or `b` high → STRAY error; stay in IDLE.
  - All inputs low → stay in IDLE.
- WAIT_A:
  - `a`=1, `b`=0, `start`=0 → WAIT_B.
  - Any other combination, including `start`=1 (overlap) → BAD_A error; go to IDLE.
- WAIT_B:
  - `b`=1, `a`=0 → `xfer_end` pulse, `xfer_cnt`+1.
    - Same cycle `start`=1 → WAIT_A (legal back-to-back transfer).
    - Otherwise → IDLE.
  - Any other combination → BAD_B error; go to IDLE. A `start` in that cycle is ignored.
- On any error:
  - `prot_err` pulses.
  - `err_code` loads the code and holds it until the next error or `clr`.
  - `err_sticky` is set.
  - `err_cnt` increments.
- Exactly one outcome per cycle; `xfer_end` and `prot_err` are never high together.
- Counters saturate at 2^`CNT_W`-1 and do not wrap.
- `clr`:
  - Zeroes `xfer_cnt`, `err_cnt`, `err_code` and `err_sticky`.
  - Does not affect the FSM, `busy` or the pulse outputs.
  - `clr` and an event in the same cycle: `clr` wins for the counters and `err_sticky`, but the pulse still fires.
- Inputs are assumed synchronous to `clk`; no X-propagation handling is required.

Test Plan:
1. Legal transfer: `rst` released; `start`=1 at edge 1, `a`=1 at edge 2, `b`=1 at edge 3 → `xfer_end`=1 for one cycle after edge 3; `xfer_cnt`=1, `err_cnt`=0, `busy` high after edges 1 and 2.
2. Back-to-back: 3 transfers with `start` asserted in each `b` cycle (`start` on edges 1,3,5; `a` on 2,4,6; `b` on 3,5,7) → `xfer_end` after edges 3, 5 and 7; `xfer_cnt`=3, no `prot_err`.
3. Violations:
   - `start`, then `b` instead of `a` → `prot_err` pulse, `err_code`=2, `err_sticky`=1, FSM in IDLE.
   - Then `start`, `a`, `a` → `err_code`=3, `err_cnt`=2.
   - Then lone `a` in IDLE → `err_code`=1, `err_cnt`=3.
4. Overlap and reset: `start`, `start` → BAD_A (`err_code`=2). Then `start`, `a`, with `rst` pulsed mid-cycle before `b` → all outputs 0 immediately, and `b` after reset → STRAY.
5. Saturation and clear: `CNT_W`=2; 5 legal transfers → `xfer_cnt`=3. Assert `clr` coincident with a STRAY event → `prot_err` pulses, `err_cnt`=0, `err_sticky`=0, `err_code`=0.
